// File: rtl/uart_rx_console.sv
// 8N1 UART receiver feeding a small FIFO that drives the Wrapper's console-input
// handshake; a byte is consumed on each rising edge of CONSOLE_IN_ack.
module uart_rx_console #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RX,
  output logic [7:0] CONSOLE_IN,
  output logic       CONSOLE_IN_valid,
  input  logic       CONSOLE_IN_ack,
  output logic       FRAME_ERR,
  output logic       OVERRUN
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int CLK_W = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CLK_W-1:0] HALF_LAST = CLK_W'(HALF - 1);
  localparam logic [CLK_W-1:0] BIT_LAST  = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] WAIT_HIGH = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] DATA      = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;

  logic             rxMeta_q, rxs_q;
  logic [2:0]       state_q, state_d;
  logic [CLK_W-1:0] clkCnt_q, clkCnt_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             frameErr_q, frameErr_d;
  logic             pushReq;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             ackPrev_q;
  logic             popEn, pushEn, fifoFull;

  // Synchroniser flops reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rxMeta_q <= 1'b1;
      rxs_q    <= 1'b1;
    end else begin
      rxMeta_q <= RX;
      rxs_q    <= rxMeta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    clkCnt_d   = clkCnt_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    frameErr_d = 1'b0;
    pushReq    = 1'b0;
    case (state_q)
      WAIT_HIGH: begin
        // A full bit time of idle line is required before trusting the next falling edge.
        if (!rxs_q) begin
          clkCnt_d = '0;
        end else if (clkCnt_q == BIT_LAST) begin
          clkCnt_d = '0;
          state_d  = IDLE;
        end else begin
          clkCnt_d = clkCnt_q + CLK_W'(1);
        end
      end
      IDLE: begin
        clkCnt_d = '0;
        if (!rxs_q) begin
          bitCnt_d = '0;
          state_d  = START;
        end
      end
      START: begin
        if (clkCnt_q == HALF_LAST) begin
          clkCnt_d = '0;
          state_d  = rxs_q ? IDLE : DATA;
        end else begin
          clkCnt_d = clkCnt_q + CLK_W'(1);
        end
      end
      DATA: begin
        if (clkCnt_q == BIT_LAST) begin
          clkCnt_d = '0;
          shift_d  = {rxs_q, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          clkCnt_d = clkCnt_q + CLK_W'(1);
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
        if (clkCnt_q == BIT_LAST) begin
          clkCnt_d = '0;
          if (rxs_q) begin
            pushReq = 1'b1;
            state_d = IDLE;
          end else begin
            frameErr_d = 1'b1;
            state_d    = WAIT_HIGH;
          end
        end else begin
          clkCnt_d = clkCnt_q + CLK_W'(1);
        end
      end
      default: begin
        clkCnt_d = '0;
        state_d  = WAIT_HIGH;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= WAIT_HIGH;
      clkCnt_q   <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clkCnt_q   <= clkCnt_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      frameErr_q <= frameErr_d;
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    fifoFull  = (count_q == FULL_CNT);
    popEn     = CONSOLE_IN_ack & ~ackPrev_q & valid_q;
    pushEn    = pushReq & (~fifoFull | popEn);
    overrun_d = overrun_q | (pushReq & fifoFull & ~popEn);
    wrPtr_d   = pushEn ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d   = popEn ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    count_d   = count_q;
    if (pushEn && !popEn) begin
      count_d = count_q + CNT_W'(1);
    end else if (popEn && !pushEn) begin
      count_d = count_q - CNT_W'(1);
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ackPrev_q <= 1'b0;
    end else begin
      if (pushEn) begin
        mem_q[wrPtr_q] <= shift_q;
      end
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ackPrev_q <= CONSOLE_IN_ack;
    end
  end

  assign CONSOLE_IN       = mem_q[rdPtr_q];
  assign CONSOLE_IN_valid = valid_q;
  assign FRAME_ERR        = frameErr_q;
  assign OVERRUN          = overrun_q;

endmodule

// File: tb/tb_uart_rx_console.sv
// Scoreboard bench for uart_rx_console: stimulus queues expected bytes, a monitor
// compares CONSOLE_IN on every acknowledge rising edge seen while valid.
module tb_uart_rx_console;

  localparam int BIT       = 16;
  localparam int STOP_EDGE = 9 * BIT + BIT / 2 + 3;

  logic       clk = 1'b0;
  logic       resetN;
  logic       rx;
  logic [7:0] consoleIn;
  logic       consoleValid;
  logic       consoleAck;
  logic       frameErr;
  logic       overrun;

  int         checks = 0;
  int         errors = 0;
  int         frameErrCnt = 0;
  logic       ackPrev = 1'b0;
  logic [7:0] expQ[$];
  logic [7:0] burstBytes [5] = '{8'h41, 8'h0D, 8'h57, 8'h43, 8'h32};

  uart_rx_console #(.CLKS_PER_BIT(BIT), .FIFO_DEPTH(4)) dut (
    .CLK(clk),
    .RESET(resetN),
    .RX(rx),
    .CONSOLE_IN(consoleIn),
    .CONSOLE_IN_valid(consoleValid),
    .CONSOLE_IN_ack(consoleAck),
    .FRAME_ERR(frameErr),
    .OVERRUN(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, req);
    end
  endtask

  function automatic logic frameLevel(input logic [7:0] d, input logic s, input int c);
    int b;
    b = c / BIT;
    if (b == 0) return 1'b0;
    else if (b <= 8) return d[b-1];
    else return s;
  endfunction

  // One full frame, one iteration per clock; mode 1 checks push timing, mode 2 frame-error timing.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int ackAt, input int mode);
    for (int c = 0; c < 10 * BIT; c++) begin
      @(posedge clk);
      #1;
      rx = frameLevel(data, stopBit, c);
      if (ackAt >= 0 && c == ackAt) consoleAck = 1'b1;
      if (ackAt >= 0 && c == ackAt + 2) consoleAck = 1'b0;
      if (mode == 1 && c == STOP_EDGE - 1) checkOutput("valid_before_push", consoleValid, 1'b0);
      if (mode == 1 && c == STOP_EDGE) checkOutput("valid_after_push", consoleValid, 1'b1);
      if (mode == 2 && c == STOP_EDGE) checkOutput("frame_err_pulse", frameErr, 1'b1);
      if (mode == 2 && c == STOP_EDGE + 1) checkOutput("frame_err_drop", frameErr, 1'b0);
    end
  endtask

  task automatic popOne(input int hold);
    int t;
    t = 0;
    while (!consoleValid && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    checkOutput("valid_before_pop", consoleValid, 1'b1);
    consoleAck = 1'b1;
    repeat (hold) @(posedge clk);
    #1 consoleAck = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #2 resetN = 1'b0;
    #5;
    checkOutput("rst_valid", consoleValid, 1'b0);
    checkOutput("rst_data", consoleIn, 8'h00);
    checkOutput("rst_overrun", overrun, 1'b0);
    checkOutput("rst_frame_err", frameErr, 1'b0);
    #15 resetN = 1'b1;
    repeat (24) @(posedge clk);
    #1;
  endtask

  task automatic monitorLoop();
    logic [7:0] expByte;
    forever begin
      @(negedge clk);
      if (resetN && consoleAck && !ackPrev && consoleValid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pop actual=%0h expected=none", consoleIn);
        end else begin
          expByte = expQ.pop_front();
          checkOutput("pop_data", consoleIn, expByte);
        end
      end
      if (frameErr) frameErrCnt++;
      ackPrev = consoleAck;
    end
  endtask

  initial begin
    int popsDone;
    int fe0;
    rx         = 1'b1;
    consoleAck = 1'b0;
    resetN     = 1'b1;
    fork
      monitorLoop();
      begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
      end
    join_none

    #2 resetN = 1'b0;
    #10;
    checkOutput("init_valid", consoleValid, 1'b0);
    checkOutput("init_data", consoleIn, 8'h00);
    checkOutput("init_overrun", overrun, 1'b0);
    checkOutput("init_frame_err", frameErr, 1'b0);
    #10 resetN = 1'b1;
    repeat (24) @(posedge clk);
    #1;

    $display("[TB] single byte");
    expQ.push_back(8'h50);
    applyStimulus(8'h50, 1'b1, -1, 1);
    popOne(3);
    checkOutput("single_valid_after_pop", consoleValid, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("single_still_empty", consoleValid, 1'b0);
    checkOutput("single_frame_err", frameErrCnt, 0);
    checkOutput("single_overrun", overrun, 1'b0);

    $display("[TB] burst and wrap");
    foreach (burstBytes[i]) expQ.push_back(burstBytes[i]);
    popsDone = 0;
    fork
      begin
        foreach (burstBytes[i]) applyStimulus(burstBytes[i], 1'b1, -1, 0);
      end
      begin
        for (int c = 0; c < 3000 && popsDone < 5; c++) begin
          @(posedge clk);
          #1;
          if (consoleAck) consoleAck = 1'b0;
          else if (consoleValid) begin
            consoleAck = 1'b1;
            popsDone++;
          end
        end
      end
    join
    consoleAck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("burst_pops", popsDone, 5);
    checkOutput("burst_queue_empty", expQ.size(), 0);
    checkOutput("burst_valid", consoleValid, 1'b0);
    checkOutput("burst_overrun", overrun, 1'b0);

    $display("[TB] overrun");
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expQ.push_back(8'(i + 1));
      applyStimulus(8'(i + 1), 1'b1, -1, 0);
      if (i == 3) checkOutput("overrun_at_full", overrun, 1'b0);
    end
    checkOutput("overrun_set", overrun, 1'b1);
    repeat (4) popOne(1);
    checkOutput("overrun_drained", consoleValid, 1'b0);
    checkOutput("overrun_queue_empty", expQ.size(), 0);
    checkOutput("overrun_sticky", overrun, 1'b1);

    $display("[TB] simultaneous push and pop at full");
    doReset();
    expQ.push_back(8'h11);
    expQ.push_back(8'h22);
    expQ.push_back(8'h33);
    expQ.push_back(8'h44);
    expQ.push_back(8'hAA);
    applyStimulus(8'h11, 1'b1, -1, 0);
    applyStimulus(8'h22, 1'b1, -1, 0);
    applyStimulus(8'h33, 1'b1, -1, 0);
    applyStimulus(8'h44, 1'b1, -1, 0);
    applyStimulus(8'hAA, 1'b1, STOP_EDGE - 1, 0);
    checkOutput("simul_overrun", overrun, 1'b0);
    checkOutput("simul_popped", expQ.size(), 4);
    repeat (4) popOne(1);
    checkOutput("simul_drained", consoleValid, 1'b0);

    $display("[TB] framing error");
    fe0 = frameErrCnt;
    expQ.push_back(8'h34);
    applyStimulus(8'h33, 1'b0, -1, 2);
    rx = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    applyStimulus(8'h34, 1'b1, -1, 0);
    checkOutput("ferr_count", frameErrCnt - fe0, 1);
    popOne(1);
    checkOutput("ferr_drained", consoleValid, 1'b0);

    $display("[TB] glitch");
    rx = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("glitch_no_output", consoleValid, 1'b0);

    $display("[TB] reset mid-frame");
    for (int c = 0; c < 10 * BIT; c++) begin
      @(posedge clk);
      #1;
      rx = frameLevel(8'h07, 1'b1, c);
      if (c == 4 * BIT + 8) begin
        #1 resetN = 1'b0;
        #5;
        checkOutput("midrst_valid", consoleValid, 1'b0);
        checkOutput("midrst_data", consoleIn, 8'h00);
        #15 resetN = 1'b1;
      end
    end
    rx = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    checkOutput("midrst_no_byte", consoleValid, 1'b0);
    expQ.push_back(8'h7E);
    applyStimulus(8'h7E, 1'b1, -1, 0);
    popOne(1);
    checkOutput("midrst_drained", consoleValid, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("final_queue_empty", expQ.size(), 0);
    checkOutput("final_frame_err_count", frameErrCnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_console.md
# uart_rx_console

UART receiver with a small receive FIFO. It deserialises 8N1 frames from the board's serial RX pin and presents bytes to the processor Wrapper's console-input port (CONSOLE_IN / CONSOLE_IN_valid / CONSOLE_IN_ack). It sits directly upstream of the Wrapper and replaces the bench-driven console stimulus in hardware builds.

## Interface
- CLKS_PER_BIT, 868, CLK cycles per UART bit (100 MHz / 115200); minimum 8.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, minimum 2.
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset asserted).
- RX  in  1  serial input, idle high; asynchronous to CLK.
- CONSOLE_IN  out  8  byte at FIFO head; reset 0x00.
- CONSOLE_IN_valid  out  1  FIFO non-empty; reset 0.
- CONSOLE_IN_ack  in  1  consumer acknowledge (level, may stay high several cycles).
- FRAME_ERR  out  1  one-cycle pulse on bad stop bit; reset 0.
- OVERRUN  out  1  sticky, set when a good byte is dropped because the FIFO is full; cleared only by reset; reset 0.

## Operation
- RX passes through a 2-flop synchroniser (flops reset to 1); the FSM uses only the synchronised value rxs.
- FSM states: WAIT_HIGH, IDLE, START, DATA, STOP. Reset state WAIT_HIGH.
- WAIT_HIGH: count consecutive cycles with rxs=1; after CLKS_PER_BIT of them go IDLE; any rxs=0 restarts the count. This discards partial frames after reset or errors.
- IDLE: rxs=0 -> START, bit counter cleared.
- START: at cycle CLKS_PER_BIT/2 (integer division) after entry, sample rxs. If 0 -> DATA. If 1 (glitch) -> IDLE with no output.
- DATA: sample every CLKS_PER_BIT cycles from the start mid-point. Shift in LSB first. After 8 samples -> STOP.
- STOP: sample CLKS_PER_BIT cycles after the last data sample.
  - rxs=1: push the byte, then -> IDLE on the same edge. If the FIFO is full and not popping, drop the byte and set OVERRUN.
  - rxs=0: FRAME_ERR pulses for that cycle, the byte is discarded, then -> WAIT_HIGH.
- FIFO: circular buffer with read/write pointers and count of width log2(FIFO_DEPTH)+1.
  - CONSOLE_IN = mem[rd_ptr].
  - CONSOLE_IN_valid = (count != 0), registered.
- Pop: on a rising edge of CONSOLE_IN_ack while valid=1. The block keeps a registered copy ack_q of CONSOLE_IN_ack; a pop occurs when ack=1 and ack_q=0. An ack held high pops exactly once. An ack while valid=0 is ignored and does not arm a later pop.
- Simultaneous push and pop: both occur and count is unchanged. When full, a simultaneous pop frees the slot, so the push is accepted and OVERRUN is not set.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- RX edge to FSM visibility: 2 cycles of synchroniser latency.
- Stop-bit sample edge (push) to CONSOLE_IN_valid=1 with the new byte: 1 cycle.
- Pop edge to next byte on CONSOLE_IN (or valid=0 if empty): 1 cycle.
- FRAME_ERR is high for exactly 1 cycle, on the cycle after the stop-bit sample edge.
- Back-to-back frames with no idle gap are received, because STOP returns to IDLE at mid-stop-bit.
- RESET low at any time, including mid-frame or mid-handshake:
  - FIFO is emptied and all outputs take their reset values immediately.
  - FSM enters WAIT_HIGH; no byte is produced from a frame in progress.

## Test plan
Bench settings: CLKS_PER_BIT=16, 10 ns CLK, RESET pulsed low for 20 ns.
- Single byte: send 0x50 with a good stop bit. CONSOLE_IN=0x50 and valid=1 one cycle after the stop sample. Hold ack high 3 cycles: exactly one pop, valid=0 afterwards, FRAME_ERR and OVERRUN stay 0.
- Burst and wrap: send 0x41, 0x0D, 0x57, 0x43, 0x32 back-to-back, popping each byte once it is valid. Bytes are delivered in order across the pointer wrap, with no OVERRUN.
- Overrun: send 5 bytes 0x01..0x05 without acking. FIFO holds 0x01..0x04 and OVERRUN=1 after the 5th stop bit. Four pops then return 0x01..0x04 in order.
- Simultaneous push and pop at full: fill with 4 bytes, then time an ack rising edge on the stop-sample cycle of 0xAA. OVERRUN stays 0 and 0xAA is the 4th entry delivered.
- Framing error: send 0x33 with stop bit 0, then RX high for 16+ cycles, then 0x34. FRAME_ERR pulses once, 0x33 is never output, and 0x34 is delivered.
- Glitch and reset: a 4-cycle low pulse on RX produces no output. Asserting RESET during data bit 3 gives valid=0, an empty FIFO, and the next full frame 0x7E received correctly.
